// File: rtl/axi_pad_trunc_pkg.sv
// Shared definitions for the AXI-stream packet length normaliser:
// settings-register offsets, mode bit positions, FSM encoding and helpers.
package axi_pad_trunc_pkg;

  // Settings-register offsets relative to SR_BASE
  localparam int unsigned SR_LEN  = 0;
  localparam int unsigned SR_MODE = 1;
  localparam int unsigned SR_FILL = 2;

  // Bit positions inside the mode register write
  localparam int unsigned MODE_PAD_EN    = 0;
  localparam int unsigned MODE_TRUNC_EN  = 1;
  localparam int unsigned MODE_CLEAR_CNT = 2;  // self-clearing, never stored

  // Statistics counters are 32 bits and stick at all-ones
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,  // zero-latency pass-through, counting output beats
    ST_PAD  = 2'd1,  // emitting fill words until the length is reached
    ST_DROP = 2'd2   // swallowing excess input beats of a truncated packet
  } state_e;

  // Stored mode bits; field order matches MODE_TRUNC_EN/MODE_PAD_EN
  typedef struct packed {
    logic trunc_en;
    logic pad_en;
  } mode_t;

  // Saturating increment for the 32-bit statistics counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == STAT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axi_pad_trunc_setting_reg.sv
// Single settings-bus register: captures set_data when set_stb hits ADDR.
// The new value is visible the cycle after the strobe.
module axi_pad_trunc_setting_reg #(
  parameter logic [7:0]        ADDR        = 8'd0,
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [WIDTH-1:0] set_data,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  // Load on an address match, otherwise hold
  always_comb begin
    // NOTE: assign every combinational output a default before any condition,
    // otherwise an unassigned path infers a latch.
    val_d = val_q;
    if (set_stb && (set_addr == ADDR)) begin
      val_d = set_data;
    end
  end

  // Register with asynchronous reset to the programmed default
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      val_q <= RESET_VALUE;
    end else begin
      val_q <= val_d;
    end
  end

  assign out = val_q;

endmodule

// File: rtl/axi_pad_trunc.sv
// AXI-stream packet length normaliser. Short packets are padded with a fill
// word up to L beats, long packets are optionally cut at L beats with the
// excess input discarded. Configuration is sampled on the first beat of each
// packet and frozen until that packet completes.
module axi_pad_trunc
  import axi_pad_trunc_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,   // 8, 16, 32 or 64
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned SR_BASE      = 128,
  parameter int unsigned DEFAULT_LEN  = 64,
  parameter int unsigned DEFAULT_MODE = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  // settings bus
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  // input stream
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  // output stream
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  // statistics / status
  output logic [31:0]      pad_count,
  output logic [31:0]      trunc_count,
  output logic             busy
);

  localparam int unsigned FILL_W    = (WIDTH > 32) ? 32 : WIDTH;
  localparam logic [7:0]  ADDR_LEN  = 8'(SR_BASE + SR_LEN);
  localparam logic [7:0]  ADDR_MODE = 8'(SR_BASE + SR_MODE);
  localparam logic [7:0]  ADDR_FILL = 8'(SR_BASE + SR_FILL);

  // ---------------------------------------------------------------------------
  // Staging registers (settings bus side)
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0]  len_stage;
  logic [1:0]        mode_stage_raw;
  logic [FILL_W-1:0] fill_stage;
  logic [WIDTH-1:0]  fill_stage_word;
  mode_t             mode_stage;

  axi_pad_trunc_setting_reg #(
    .ADDR        (ADDR_LEN),
    .WIDTH       (LEN_W),
    .RESET_VALUE (LEN_W'(DEFAULT_LEN))
  ) u_sr_len (
    .clk      (clk),
    .rst_n    (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data[LEN_W-1:0]),
    .out      (len_stage)
  );

  axi_pad_trunc_setting_reg #(
    .ADDR        (ADDR_MODE),
    .WIDTH       (2),
    .RESET_VALUE (2'(DEFAULT_MODE))
  ) u_sr_mode (
    .clk      (clk),
    .rst_n    (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data[MODE_TRUNC_EN:MODE_PAD_EN]),
    .out      (mode_stage_raw)
  );

  axi_pad_trunc_setting_reg #(
    .ADDR        (ADDR_FILL),
    .WIDTH       (FILL_W),
    .RESET_VALUE ('0)
  ) u_sr_fill (
    .clk      (clk),
    .rst_n    (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data[FILL_W-1:0]),
    .out      (fill_stage)
  );

  assign mode_stage = mode_t'(mode_stage_raw);

  // A 64-bit stream repeats the 32-bit fill in both halves
  generate
    if (WIDTH == 64) begin : g_fill_wide
      assign fill_stage_word = {2{fill_stage}};
    end else begin : g_fill_narrow
      assign fill_stage_word = fill_stage;
    end
  endgenerate

  // Counter clear is a pulse decoded straight off the bus, not a stored bit
  logic clear_counts;
  assign clear_counts = set_stb && (set_addr == ADDR_MODE) && set_data[MODE_CLEAR_CNT];

  // ---------------------------------------------------------------------------
  // State, beat counter, active (frozen) configuration, statistics
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sop_q, sop_d;
  logic [LEN_W-1:0] len_act_q, len_act_d;
  mode_t            mode_act_q, mode_act_d;
  logic [WIDTH-1:0] fill_act_q, fill_act_d;
  logic [31:0]      pad_cnt_q, pad_cnt_d;
  logic [31:0]      trunc_cnt_q, trunc_cnt_d;

  // Effective configuration: staging at a boundary, frozen copy mid-packet
  logic [LEN_W-1:0] eff_len;
  mode_t            eff_mode;
  logic [WIDTH-1:0] eff_fill;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] cnt_inc;
  logic             at_len;
  logic             short_pkt;
  logic             at_or_past_len;
  logic             in_beat;
  logic             first_beat;
  logic             pad_done;
  logic             trunc_start;

  assign eff_len  = sop_q ? len_stage       : len_act_q;
  assign eff_mode = sop_q ? mode_stage      : mode_act_q;
  assign eff_fill = sop_q ? fill_stage_word : fill_act_q;

  // A programmed length of 0 behaves exactly like a length of 1
  assign len_m1         = (eff_len == '0) ? '0 : eff_len - LEN_W'(1);
  assign cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
  assign at_len         = (cnt_q == len_m1);
  assign short_pkt      = (cnt_q <  len_m1);
  assign at_or_past_len = (cnt_q >= len_m1);

  assign in_beat    = i_tvalid && o_tready;
  assign first_beat = sop_q && (state_q == ST_PASS) && in_beat;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic together with beat counter and packet boundary tracking
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sop_d       = sop_q;
    pad_done    = 1'b0;
    trunc_start = 1'b0;
    unique case (state_q)
      ST_PASS: begin
        if (in_beat) begin
          sop_d = 1'b0;
          if (i_tlast) begin
            if (short_pkt && eff_mode.pad_en) begin
              state_d = ST_PAD;
              cnt_d   = cnt_inc;
            end else begin
              // exact length, unpadded short packet, or untruncated long one
              cnt_d = '0;
              sop_d = 1'b1;
            end
          end else if (at_or_past_len && eff_mode.trunc_en) begin
            state_d     = ST_DROP;
            trunc_start = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_PAD: begin
        if (o_tready) begin
          if (at_len) begin
            state_d  = ST_PASS;
            cnt_d    = '0;
            sop_d    = 1'b1;
            pad_done = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DROP: begin
        if (i_tvalid && i_tlast) begin
          state_d = ST_PASS;
          cnt_d   = '0;
          sop_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_PASS;
        cnt_d   = '0;
        sop_d   = 1'b1;
      end
    endcase
  end

  // Snapshot the staging configuration on the first accepted beat of a packet
  always_comb begin
    len_act_d  = len_act_q;
    mode_act_d = mode_act_q;
    fill_act_d = fill_act_q;
    if (first_beat) begin
      len_act_d  = len_stage;
      mode_act_d = mode_stage;
      fill_act_d = fill_stage_word;
    end
  end

  // Saturating statistics; a clear pulse beats a same-cycle increment
  always_comb begin
    pad_cnt_d   = pad_done    ? sat_inc32(pad_cnt_q)   : pad_cnt_q;
    trunc_cnt_d = trunc_start ? sat_inc32(trunc_cnt_q) : trunc_cnt_q;
    if (clear_counts) begin
      pad_cnt_d   = '0;
      trunc_cnt_d = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      sop_q       <= 1'b1;
      len_act_q   <= LEN_W'(DEFAULT_LEN);
      mode_act_q  <= mode_t'(2'(DEFAULT_MODE));
      fill_act_q  <= '0;
      pad_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sop_q       <= sop_d;
      len_act_q   <= len_act_d;
      mode_act_q  <= mode_act_d;
      fill_act_q  <= fill_act_d;
      pad_cnt_q   <= pad_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  // Stream outputs per state; everything is held at 0 while reset is asserted
  // so no handshake can complete during or straight out of an async reset.
  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    i_tready = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_PASS: begin
          o_tvalid = i_tvalid;
          o_tdata  = i_tdata;
          i_tready = o_tready;
          o_tlast  = i_tlast ? !(short_pkt && eff_mode.pad_en)
                             : (at_or_past_len && eff_mode.trunc_en);
        end
        ST_PAD: begin
          o_tvalid = 1'b1;
          o_tdata  = eff_fill;
          o_tlast  = at_len;
        end
        ST_DROP: begin
          i_tready = 1'b1;
        end
        default: begin
          o_tvalid = 1'b0;
        end
      endcase
    end
  end

  assign pad_count   = pad_cnt_q;
  assign trunc_count = trunc_cnt_q;
  assign busy        = !sop_q;

endmodule

// File: tb/tb_axi_pad_trunc.sv
// Scoreboard bench for axi_pad_trunc: a packet-level model predicts every
// output beat, a monitor compares each accepted output beat against it.
module tb_axi_pad_trunc;

  localparam int WIDTH   = 32;
  localparam int LEN_W   = 16;
  localparam int SR_BASE = 128;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             set_stb = 1'b0;
  logic [7:0]       set_addr = '0;
  logic [31:0]      set_data = '0;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tlast = 1'b0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready = 1'b1;
  logic [31:0]      pad_count;
  logic [31:0]      trunc_count;
  logic             busy;

  always #5 clk = ~clk;

  axi_pad_trunc #(
    .WIDTH        (WIDTH),
    .LEN_W        (LEN_W),
    .SR_BASE      (SR_BASE),
    .DEFAULT_LEN  (64),
    .DEFAULT_MODE (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .i_tdata     (i_tdata),
    .i_tlast     (i_tlast),
    .i_tvalid    (i_tvalid),
    .i_tready    (i_tready),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_tvalid    (o_tvalid),
    .o_tready    (o_tready),
    .pad_count   (pad_count),
    .trunc_count (trunc_count),
    .busy        (busy)
  );

  typedef logic [31:0] word_q_t[$];
  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        is_pad;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_pct = 100;

  // Reference configuration and statistics as the bench believes them to be
  logic [15:0] m_len  = 16'd64;
  logic [1:0]  m_mode = 2'd3;
  logic [31:0] m_fill = 32'd0;
  logic [31:0] m_pad_cnt = 32'd0;
  logic [31:0] m_trunc_cnt = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_q_t seq(input int n, input logic [31:0] start);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(start + 32'(i));
    return q;
  endfunction

  // Packet-level model: whole packet in, expected output beats out
  task automatic predict(input word_q_t pkt);
    int n;
    int leff;
    int nout;
    beat_t b;
    n    = pkt.size();
    leff = (m_len == 16'd0) ? 1 : int'(m_len);
    nout = n;
    if (n < leff && m_mode[0]) begin
      nout = leff;
      m_pad_cnt++;
    end else if (n > leff && m_mode[1]) begin
      nout = leff;
      m_trunc_cnt++;
    end
    for (int i = 0; i < nout; i++) begin
      b.is_pad = (i >= n);
      b.data   = b.is_pad ? m_fill : pkt[i];
      b.last   = (i == nout - 1);
      exp_q.push_back(b);
    end
  endtask

  // All stimulus tasks start and end one time unit after a rising edge
  task automatic write_reg(input int off, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(SR_BASE + off);
    set_data = data;
    @(posedge clk); #1;
    set_stb  = 1'b0;
    case (off)
      0: m_len = data[15:0];
      1: begin
        m_mode = data[1:0];
        if (data[2]) begin
          m_pad_cnt   = 0;
          m_trunc_cnt = 0;
        end
      end
      default: m_fill = data;
    endcase
  endtask

  task automatic drive_beat(input logic [31:0] data, input logic last);
    bit acc;
    acc      = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = data;
    i_tlast  = last;
    for (int n = 0; n < 1000 && !acc; n++) begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk); #1;
    end
    check("input_beat_accepted", 64'(acc), 64'd1);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic send_packet(input word_q_t pkt, input bit gaps,
                             input bit mid_en, input logic [15:0] mid_len);
    predict(pkt);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk); #1;
        end
      end
      drive_beat(pkt[i], i == pkt.size() - 1);
      if (i == 0 && mid_en) write_reg(0, {16'd0, mid_len});
    end
  endtask

  task automatic drain_and_check(input string tag);
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_pad_count"}, 64'(pad_count), 64'(m_pad_cnt));
    check({tag, "_trunc_count"}, 64'(trunc_count), 64'(m_trunc_cnt));
    @(posedge clk); #1;
  endtask

  // Downstream back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      o_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: compare each accepted output beat, and check stalled beats hold
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    beat_t b;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(o_tvalid), 64'd1);
        check("stall_hold_data", 64'(o_tdata), 64'(prev_data));
        check("stall_hold_last", 64'(o_tlast), 64'(prev_last));
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_beat: got data 0x%0h last %0b, expected no beat at %0t",
                   o_tdata, o_tlast, $time);
        end else begin
          b = exp_q.pop_front();
          check("out_data", 64'(o_tdata), 64'(b.data));
          check("out_last", 64'(o_tlast), 64'(b.last));
          if (b.is_pad) check("in_ready_low_in_pad", 64'(i_tready), 64'd0);
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_q_t p;
    int      n;

    // Reset: handshakes forced low even with upstream valid and downstream ready
    i_tvalid = 1'b1;
    i_tdata  = 32'hA5A5_A5A5;
    #12;
    check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_i_tready", 64'(i_tready), 64'd0);
    check("rst_o_tdata", 64'(o_tdata), 64'd0);
    check("rst_o_tlast", 64'(o_tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pad_count", 64'(pad_count), 64'd0);
    check("rst_trunc_count", 64'(trunc_count), 64'd0);
    i_tvalid = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: short packet padded with zeros
    write_reg(0, 32'd4);
    write_reg(1, 32'd3);
    p = '{32'h11, 32'h22};
    send_packet(p, 1'b0, 1'b0, 16'd0);
    drain_and_check("t1_pad");

    // 2: long packet truncated, excess beats swallowed
    send_packet(seq(6, 32'd1), 1'b0, 1'b0, 16'd0);
    drain_and_check("t2_trunc");

    // 3: exact length passes unchanged
    send_packet(seq(4, 32'h100), 1'b0, 1'b0, 16'd0);
    drain_and_check("t3_exact");

    // 4: pass-through modes
    write_reg(1, 32'd1);
    send_packet(seq(6, 32'h200), 1'b0, 1'b0, 16'd0);
    drain_and_check("t4_pad_only_long");
    write_reg(1, 32'd2);
    send_packet(seq(2, 32'h300), 1'b0, 1'b0, 16'd0);
    drain_and_check("t4_trunc_only_short");

    // 5: fill word, and a length change mid-packet applies to the next packet
    write_reg(1, 32'd3);
    write_reg(2, 32'hDEAD_BEEF);
    send_packet(seq(2, 32'h400), 1'b0, 1'b1, 16'd8);
    drain_and_check("t5_old_len");
    send_packet(seq(2, 32'h500), 1'b0, 1'b0, 16'd0);
    drain_and_check("t5_new_len");

    // Randomized configurations, lengths, gaps and back-pressure
    ready_pct = 50;
    for (int k = 0; k < 30; k++) begin
      write_reg(0, 32'($urandom_range(0, 8)));
      write_reg(1, 32'($urandom_range(0, 3)));
      write_reg(2, $urandom());
      n = $urandom_range(1, 10);
      p = {};
      for (int i = 0; i < n; i++) p.push_back($urandom());
      send_packet(p, 1'b1, 1'b0, 16'd0);
      drain_and_check("rand");
    end

    // Clear statistics
    write_reg(1, 32'd7);
    @(negedge clk);
    check("clear_pad_count", 64'(pad_count), 64'(m_pad_cnt));
    check("clear_trunc_count", 64'(trunc_count), 64'(m_trunc_cnt));
    @(posedge clk); #1;

    // 6: padding under 50% back-pressure, then async reset in the middle of PAD
    write_reg(2, 32'h0);
    write_reg(0, 32'd6);
    send_packet(seq(2, 32'h600), 1'b0, 1'b0, 16'd0);
    drain_and_check("t6_bp_pad");
    write_reg(0, 32'd16);
    send_packet(seq(1, 32'h700), 1'b0, 1'b0, 16'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("t6_busy_in_pad", 64'(busy), 64'd1);
    check("t6_still_padding", 64'(exp_q.size() > 0), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("t6_rst_i_tready", 64'(i_tready), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    m_len       = 16'd64;
    m_mode      = 2'd3;
    m_fill      = 32'd0;
    m_pad_cnt   = 32'd0;
    m_trunc_cnt = 32'd0;
    @(posedge clk);
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    write_reg(0, 32'd4);
    send_packet(seq(1, 32'h800), 1'b0, 1'b0, 16'd0);
    drain_and_check("t6_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
